// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame scheduler.
// States, default transform length, sample-index width helper, imaginary pad.
package fft_pkg;

   localparam int TRANSFORM_LEN_DEF = 256;

   // The FFT core takes complex input; ADC samples are real, imaginary half is zero.
   localparam logic [15:0] IMAG_ZERO = 16'd0;

   typedef enum logic [2:0] {
      IDLE,
      CFG,
      WAIT_START,
      FEED,
      DRAIN,
      HOLD
   } state_t;

   // Width of a counter indexing one frame (0 .. len-1).
   function automatic int idx_w(input int len);
      return (len > 1) ? $clog2(len) : 1;
   endfunction

endpackage

// File: rtl/fft_axis_skid.sv
// One-entry valid/ready output register feeding the FFT input stream.
// Loads when the register is empty or is being drained in the same cycle.
module fft_axis_skid #(
   parameter int W = 33
) (
   input  logic         wd_clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready
);

   assign in_ready = !out_valid || out_ready;

   // Output register: hold data until accepted, refill on the same cycle.
   always_ff @(posedge wd_clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         // NOTE: the data register is reset too, because every output of the block must read 0 during reset.
         out_data  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep this register's update order-independent of every other always_ff.
         if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fft_frame_sched.sv
// FFT input-side frame scheduler (wd_clk domain): config once, frame the
// ADC samples with tlast, wait for the output frame, pace with start_flag.
// Optional feature: define FFT_FRAME_HOLDOFF_EN to add holdoff_len and the HOLD state.
module fft_frame_sched
   import fft_pkg::*;
#(
   parameter int TRANSFORM_LEN = TRANSFORM_LEN_DEF,
   parameter int ADC_W         = 12,
   parameter int CFG_W         = 16,
   parameter int HOLDOFF_W     = 16
) (
   input  logic             wd_clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             start_flag,
   input  logic [CFG_W-1:0] cfg_word,
   input  logic [ADC_W-1:0] adc_data,
   input  logic             adc_valid,
`ifdef FFT_FRAME_HOLDOFF_EN
   input  logic [HOLDOFF_W-1:0] holdoff_len,
`endif
   output logic [CFG_W-1:0] m_cfg_tdata,
   output logic             m_cfg_tvalid,
   input  logic             m_cfg_tready,
   output logic [31:0]      fft_in_tdata,
   output logic             fft_in_tvalid,
   output logic             fft_in_tlast,
   input  logic             fft_in_tready,
   input  logic             fft_out_valid,
   input  logic             fft_out_last,
   output logic             busy,
   output logic [15:0]      frame_cnt,
   output logic [15:0]      drop_cnt,
   output logic             err
);

   localparam int               IDX_W    = idx_w(TRANSFORM_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRANSFORM_LEN - 1);

   state_t           state, state_nxt;
   logic [CFG_W-1:0] cfg_q;
   logic [IDX_W-1:0] sample_idx;  // index of the next sample to load
   logic [IDX_W-1:0] beat_cnt;    // output beats seen in DRAIN
   logic             all_loaded;  // whole frame already loaded into the register
   logic             beat_long;   // output frame ran past TRANSFORM_LEN beats
   logic             skid_in_valid, skid_in_ready, beat_acc, drop_evt;
   logic             frame_start, frame_done;
   logic [15:0]      re_ext;
   logic [32:0]      skid_in_data, skid_out_data;
`ifdef FFT_FRAME_HOLDOFF_EN
   logic [HOLDOFF_W-1:0] hold_cnt;
`endif

   assign re_ext        = 16'($signed(adc_data));
   assign skid_in_data  = {sample_idx == LAST_IDX, IMAG_ZERO, re_ext};
   assign skid_in_valid = (state == FEED) && adc_valid && !all_loaded;
   assign beat_acc      = fft_in_tvalid && fft_in_tready;
   assign drop_evt      = (state == FEED) && adc_valid && fft_in_tvalid && !fft_in_tready;
   assign frame_start   = (state == WAIT_START) && enable && start_flag;
   assign frame_done    = (state == DRAIN) && fft_out_valid && fft_out_last;

   assign m_cfg_tvalid  = (state == CFG);
   assign m_cfg_tdata   = cfg_q;
   assign busy          = (state != IDLE);
   assign fft_in_tdata  = skid_out_data[31:0];
   assign fft_in_tlast  = skid_out_data[32];

   fft_axis_skid #(.W(33)) u_skid (
      .wd_clk    (wd_clk),
      .rst_n     (rst_n),
      .in_valid  (skid_in_valid),
      .in_data   (skid_in_data),
      .in_ready  (skid_in_ready),
      .out_valid (fft_in_tvalid),
      .out_data  (skid_out_data),
      .out_ready (fft_in_tready)
   );

   // State register.
   always_ff @(posedge wd_clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         IDLE:       if (enable) state_nxt = CFG;
         CFG:        if (m_cfg_tready) state_nxt = WAIT_START;
         WAIT_START: begin
            if (!enable)         state_nxt = IDLE;
            else if (start_flag) state_nxt = FEED;
         end
         FEED:       if (beat_acc && fft_in_tlast) state_nxt = DRAIN;
`ifdef FFT_FRAME_HOLDOFF_EN
         DRAIN:      if (frame_done) state_nxt = HOLD;
         HOLD:       if (hold_cnt <= HOLDOFF_W'(1)) state_nxt = WAIT_START;
`else
         DRAIN:      if (frame_done) state_nxt = WAIT_START;
`endif
         default:    state_nxt = IDLE;
      endcase
   end

   // Config capture, frame counters, drop/error bookkeeping.
   always_ff @(posedge wd_clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q      <= '0;
         sample_idx <= '0;
         beat_cnt   <= '0;
         all_loaded <= 1'b0;
         beat_long  <= 1'b0;
         frame_cnt  <= '0;
         drop_cnt   <= '0;
         err        <= 1'b0;
`ifdef FFT_FRAME_HOLDOFF_EN
         hold_cnt   <= '0;
`endif
      end else begin
         if (state == IDLE && enable) cfg_q <= cfg_word;

         if (frame_start) begin
            sample_idx <= '0;
            all_loaded <= 1'b0;
            beat_cnt   <= '0;
            beat_long  <= 1'b0;
         end else if (skid_in_valid && skid_in_ready) begin
            sample_idx <= sample_idx + 1'b1;
            if (sample_idx == LAST_IDX) all_loaded <= 1'b1;
         end

         if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;

         if (state == DRAIN && fft_out_valid) begin
            if (fft_out_last) begin
               frame_cnt <= frame_cnt + 16'd1;
               if (beat_long || beat_cnt != LAST_IDX) err <= 1'b1;
               beat_cnt  <= '0;
               beat_long <= 1'b0;
`ifdef FFT_FRAME_HOLDOFF_EN
               hold_cnt  <= holdoff_len;
`endif
            end else begin
               if (beat_cnt == LAST_IDX) beat_long <= 1'b1;
               beat_cnt <= beat_cnt + 1'b1;
            end
         end

`ifdef FFT_FRAME_HOLDOFF_EN
         if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched (default build, TRANSFORM_LEN=256).
module tb_fft_frame_sched;
   import fft_pkg::*;

   logic        wd_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0, start_flag = 1'b0;
   logic [15:0] cfg_word = '0;
   logic [11:0] adc_data = '0;
   logic        adc_valid = 1'b0;
   logic [15:0] m_cfg_tdata;
   logic        m_cfg_tvalid;
   logic        m_cfg_tready = 1'b0;
   logic [31:0] fft_in_tdata;
   logic        fft_in_tvalid, fft_in_tlast;
   logic        fft_in_tready = 1'b0;
   logic        fft_out_valid = 1'b0, fft_out_last = 1'b0;
   logic        busy, err;
   logic [15:0] frame_cnt, drop_cnt;
`ifdef FFT_FRAME_HOLDOFF_EN
   logic [15:0] holdoff_len = '0;
`endif

   int checks = 0;
   int errors = 0;

   // Stream monitor (only increments; the stimulus takes snapshots).
   int cfg_xfers = 0;
   int beats     = 0;
   int last_cnt  = 0;
   int last_pos  = 0;
   int data_bad  = 0;

   fft_frame_sched dut (
      .wd_clk        (wd_clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .start_flag    (start_flag),
      .cfg_word      (cfg_word),
      .adc_data      (adc_data),
      .adc_valid     (adc_valid),
`ifdef FFT_FRAME_HOLDOFF_EN
      .holdoff_len   (holdoff_len),
`endif
      .m_cfg_tdata   (m_cfg_tdata),
      .m_cfg_tvalid  (m_cfg_tvalid),
      .m_cfg_tready  (m_cfg_tready),
      .fft_in_tdata  (fft_in_tdata),
      .fft_in_tvalid (fft_in_tvalid),
      .fft_in_tlast  (fft_in_tlast),
      .fft_in_tready (fft_in_tready),
      .fft_out_valid (fft_out_valid),
      .fft_out_last  (fft_out_last),
      .busy          (busy),
      .frame_cnt     (frame_cnt),
      .drop_cnt      (drop_cnt),
      .err           (err)
   );

   always #5 wd_clk = ~wd_clk;

   always @(posedge wd_clk) begin
      if (m_cfg_tvalid && m_cfg_tready) cfg_xfers++;
      if (fft_in_tvalid && fft_in_tready) begin
         beats++;
         if (fft_in_tdata !== 32'h0000FFFF) data_bad++;
         if (fft_in_tlast) begin
            last_cnt++;
            last_pos = beats;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; stimulus and sampling happen 1 time unit after the edge.
   task automatic tick();
      @(posedge wd_clk);
      #1;
   endtask

   initial begin
      int base_beats, base_last, base_bad;

      // ---- reset state ----
      #12;
      check("rst_busy", busy, 0);
      check("rst_cfg_tvalid", m_cfg_tvalid, 0);
      check("rst_cfg_tdata", m_cfg_tdata, 0);
      check("rst_in_tvalid", fft_in_tvalid, 0);
      check("rst_cnts", {frame_cnt, drop_cnt, 15'd0, err}, 0);

      // ---- config handshake, ready delayed 3 cycles ----
      tick();
      rst_n = 1'b1; enable = 1'b1; cfg_word = 16'h0155;
      tick();                                    // IDLE -> CFG
      check("cfg_v1", m_cfg_tvalid, 1);
      check("cfg_d1", m_cfg_tdata, 16'h0155);
      check("cfg_busy", busy, 1);
      cfg_word = 16'hAAAA;                       // later changes must not leak
      tick();
      check("cfg_v2", m_cfg_tvalid, 1);
      check("cfg_d2", m_cfg_tdata, 16'h0155);
      tick();
      check("cfg_v3", m_cfg_tvalid, 1);
      m_cfg_tready = 1'b1;
      tick();                                    // handshake -> WAIT_START
      check("cfg_drop", m_cfg_tvalid, 0);
      repeat (3) tick();
      m_cfg_tready = 1'b0;
      check("cfg_once", cfg_xfers, 1);
      check("ws_no_tvalid", fft_in_tvalid, 0);
      check("ws_busy", busy, 1);

      // ---- frame 1: continuous samples, tready=1, adc_data=-1 ----
      base_beats = beats; base_last = last_cnt; base_bad = data_bad;
      adc_data = 12'hFFF; adc_valid = 1'b1; fft_in_tready = 1'b1; start_flag = 1'b1;
      tick();                                    // WAIT_START -> FEED
      start_flag = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (last_cnt != base_last) break;
         tick();
      end
      check("f1_done", last_cnt - base_last, 1);
      check("f1_beats", beats - base_beats, 256);
      check("f1_last_pos", last_pos - base_beats, 256);
      check("f1_data", data_bad - base_bad, 0);
      check("f1_drain_busy", busy, 1);
      repeat (3) tick();                         // adc_valid still high in DRAIN
      check("f1_drain_quiet", beats - base_beats, 256);
      check("f1_no_drop", drop_cnt, 0);

      // Output frame of exactly 256 beats.
      for (int i = 0; i < 256; i++) begin
         fft_out_valid = 1'b1; fft_out_last = (i == 255);
         tick();
      end
      fft_out_valid = 1'b0; fft_out_last = 1'b0;
      check("f1_frame_cnt", frame_cnt, 1);
      check("f1_err", err, 0);

      // start_flag low: no new frame; stray output beat outside DRAIN ignored.
      repeat (5) tick();
      check("nostart_beats", beats - base_beats, 256);
      check("nostart_tvalid", fft_in_tvalid, 0);
      fft_out_valid = 1'b1; fft_out_last = 1'b1;
      tick();
      fft_out_valid = 1'b0; fft_out_last = 1'b0;
      check("stray_frame_cnt", frame_cnt, 1);
      check("stray_err", err, 0);

      // ---- frame 2: stall, drops, enable dropped mid-frame ----
      // Edge 99 has no sample so the register drains; at edge 100 tready goes
      // low for 5 edges: edge 100 loads sample 100, edges 101..104 drop 4.
      base_beats = beats; base_last = last_cnt;
      start_flag = 1'b1;
      tick();                                    // WAIT_START -> FEED
      start_flag = 1'b0;
      for (int k = 0; k < 600; k++) begin
         if (last_cnt != base_last) break;
         adc_data      = 12'(k);
         adc_valid     = (k != 99);
         fft_in_tready = !(k >= 100 && k < 105);
         if (k == 50) enable = 1'b0;
         tick();
         if (k >= 100 && k < 105) begin
            check("stall_tvalid", fft_in_tvalid, 1);
            check("stall_tdata", fft_in_tdata, 32'h0000_0064);
         end
      end
      fft_in_tready = 1'b1;
      check("f2_done", last_cnt - base_last, 1);
      check("f2_beats", beats - base_beats, 256);
      check("f2_last_pos", last_pos - base_beats, 256);
      check("f2_drops", drop_cnt, 4);
      check("f2_drain_busy", busy, 1);

      // Short output frame: last on beat 200.
      for (int i = 0; i < 200; i++) begin
         fft_out_valid = 1'b1; fft_out_last = (i == 199);
         tick();
      end
      fft_out_valid = 1'b0; fft_out_last = 1'b0;
      check("f2_frame_cnt", frame_cnt, 2);
      check("f2_err", err, 1);
      tick();                                    // WAIT_START sees enable=0
      check("f2_idle", busy, 0);
      repeat (3) tick();
      check("err_sticky", err, 1);

      // ---- re-enable, new config, then async reset mid-FEED ----
      cfg_word = 16'h0A0F; enable = 1'b1; m_cfg_tready = 1'b1;
      tick();                                    // IDLE -> CFG
      check("cfg2_data", m_cfg_tdata, 16'h0A0F);
      tick();                                    // handshake
      check("cfg2_xfers", cfg_xfers, 2);
      m_cfg_tready = 1'b0;
      adc_data = 12'h800; adc_valid = 1'b1; fft_in_tready = 1'b0; start_flag = 1'b1;
      tick();                                    // -> FEED
      tick();                                    // sample loaded
      check("neg_tvalid", fft_in_tvalid, 1);
      check("neg_tdata", fft_in_tdata, 32'h0000_F800);
      #3 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_tvalid", fft_in_tvalid, 0);
      check("arst_tdata", {fft_in_tlast, fft_in_tdata}, 0);
      check("arst_cnts", {frame_cnt, drop_cnt, 15'd0, err}, 0);
      check("arst_cfg", {m_cfg_tvalid, m_cfg_tdata}, 0);
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_frame_sched.md
Name: fft_frame_sched

Overview:
- Sequences the FFT core's input side in the wd_clk domain: issues the core's configuration word once, gates ADC samples into AXI-Stream frames of TRANSFORM_LEN samples with tlast, and waits for the output frame before starting the next.
- Paces frame starts with the FIFO-level start flag from the FFT→HDMI FIFO controller, so the display FIFO never overflows.
- Sits between the ADC capture logic and the FFT IP.

Parameters:
- TRANSFORM_LEN, 256, samples per FFT frame (power of 2, 16..4096).
- ADC_W, 12, ADC sample width (≤16).
- CFG_W, 16, FFT config word width.
- HOLDOFF_W, 16, width of the inter-frame holdoff counter (used only with the optional feature).

Ports:
- wd_clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run enable; sampled only in IDLE and WAIT_START.
- start_flag  in  1  FIFO has room for one spectrum (data_input_start_flag).
- cfg_word  in  CFG_W  FFT config (direction/scaling); captured on leaving IDLE.
- adc_data  in  ADC_W  signed ADC sample.
- adc_valid  in  1  one-cycle sample strobe.
- m_cfg_tdata  out  CFG_W  config to FFT core.
- m_cfg_tvalid  out  1  config valid.
- m_cfg_tready  in  1  config ready.
- fft_in_tdata  out  32  {16'd0 imag, sign-extended real}.
- fft_in_tvalid  out  1  sample valid.
- fft_in_tlast  out  1  last sample of frame.
- fft_in_tready  in  1  FFT input ready.
- fft_out_valid  in  1  FFT output beat.
- fft_out_last  in  1  last output beat of frame.
- busy  out  1  state ≠ IDLE.
- frame_cnt  out  16  completed output frames, wraps.
- drop_cnt  out  16  ADC samples dropped inside FEED, saturates at 16'hFFFF.
- err  out  1  sticky: output frame length ≠ TRANSFORM_LEN.

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0.
- States: IDLE → CFG → WAIT_START → FEED → DRAIN → (HOLD) → WAIT_START.
- IDLE:
  - If enable=1: capture cfg_word and go to CFG.
- CFG:
  - m_cfg_tvalid=1 with the captured word.
  - On m_cfg_tvalid&m_cfg_tready: drop valid and go to WAIT_START.
  - Happens once per IDLE exit; tdata is stable while valid.
- WAIT_START:
  - enable=0 → IDLE.
  - Else if start_flag=1 → FEED, with sample counter = 0.
  - start_flag is level-sampled, not edge-sampled.
- FEED output stage:
  - Single output register; a sample is loaded when adc_valid=1 and the register is empty or being accepted this cycle.
  - Latency: adc_valid to fft_in_tvalid is 1 cycle.
  - tdata, tvalid and tlast hold until tready.
  - tlast=1 on sample index TRANSFORM_LEN-1.
  - After the tlast beat is accepted → DRAIN; later adc_valid strobes are ignored and not counted.
- FEED drops:
  - adc_valid=1 while the register is full and tready=0: sample lost, drop_cnt +1 (saturating).
  - The frame still completes with TRANSFORM_LEN accepted samples.
- enable deassert in FEED/DRAIN: ignored; the frame completes.
- DRAIN:
  - Count fft_out_valid beats.
  - On fft_out_valid&fft_out_last: frame_cnt +1 (wraps).
  - If beat count+1 ≠ TRANSFORM_LEN, set err.
  - Then go to HOLD if the feature is present, else WAIT_START.
- Output beats outside DRAIN: ignored.
- Asynchronous reset mid-frame: immediate return to IDLE, tvalid low. The FFT core must be reset together with this block.
- err: cleared only by reset.

Optional Feature:
- Macro FFT_FRAME_HOLDOFF_EN.
- Defined:
  - Adds input holdoff_len[HOLDOFF_W-1:0], sampled on DRAIN exit.
  - HOLD state waits holdoff_len cycles before WAIT_START, to lower the spectrum refresh rate.
  - holdoff_len=0 gives a 1-cycle HOLD.
- Undefined: no port and no HOLD state; DRAIN → WAIT_START directly.

Decomposition:
- Package fft_pkg:
  - state enum {IDLE, CFG, WAIT_START, FEED, DRAIN, HOLD}.
  - TRANSFORM_LEN default.
  - clog2-based sample-count width.
  - Constant for the imaginary zero pad.
- Sub-module fft_axis_skid: one-entry valid/ready output register used in FEED.

Test Plan:
- Reset, enable=1, cfg_word=16'h0155, m_cfg_tready delayed 3 cycles → m_cfg_tvalid held 3 cycles with tdata 16'h0155, exactly one transfer, then WAIT_START.
- start_flag=1, continuous adc_valid, tready=1, adc_data=12'hFFF → 256 beats, tdata=32'h0000FFFF, tlast only on beat 256, busy=1.
- tready low for 5 cycles mid-frame while adc_valid every cycle → drop_cnt=4 (one sample held in the register), still 256 accepted beats, tdata stable while stalled.
- FFT output of 256 beats with last on beat 256 → frame_cnt=1, err=0; a second frame with last on beat 200 → frame_cnt=2, err=1 and sticky.
- start_flag=0 after DRAIN → no tvalid until start_flag=1; enable=0 in FEED → frame finishes, then IDLE; async rst_n pulse mid-FEED → all outputs 0 at once.
- With FFT_FRAME_HOLDOFF_EN, holdoff_len=10 → next FEED begins 10 cycles after DRAIN exit plus the WAIT_START cycle; holdoff_len=0 → 1-cycle HOLD.
